// File: rtl/codificador_sequencial_parametrizado.sv
// codificador_sequencial_parametrizado: debounced line encoder with valid/ready handshake and overrun flag
module codificador_sequencial_parametrizado #(
    parameter int N_ENTRADAS      = 7,
    parameter int LARGURA_CF      = $clog2(N_ENTRADAS + 1),
    parameter int CICLOS_ESTAVEL  = 4,
    parameter int MODO_PRIORIDADE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_ENTRADAS-1:0] entrada,
    input  logic                  saida_pronta,
    input  logic                  limpa_erro,
    output logic [LARGURA_CF-1:0] codigo,
    output logic                  saida_valida,
    output logic                  erro_multiplo,
    output logic                  sobrescrita
);
    typedef enum logic {OCIOSO, VALIDO} estado_t;
    estado_t               estado;
    logic [N_ENTRADAS-1:0] amostra;
    logic [N_ENTRADAS-1:0] filtrado;
    logic [7:0]            contador;
    logic                  estavel;
    logic                  evento;
    logic                  multiplo;
    logic [LARGURA_CF-1:0] codigo_novo;
    int                    alto;

    // encode the held sample; the highest set index is the first line in priority order
    always_comb begin
        alto = 0;
        for (int i = 0; i < N_ENTRADAS; i++)
            if (amostra[i]) alto = i;
        multiplo    = $countones(amostra) > 1;
        estavel     = entrada == amostra;
        evento      = estavel && contador == 8'(CICLOS_ESTAVEL - 1) && amostra != filtrado;
        codigo_novo = (amostra == '0 || (multiplo && MODO_PRIORIDADE == 0)) ? '0 : LARGURA_CF'(N_ENTRADAS - alto);
    end

    // stability filter: count consecutive edges with an unchanged input, saturating at the target
    always_ff @(posedge clk) begin
        if (reset) begin
            amostra  <= '0;
            contador <= '0;
        end else begin
            amostra  <= entrada;
            contador <= !estavel ? 8'd0 : contador == 8'(CICLOS_ESTAVEL) ? contador : contador + 8'd1;
        end
    end

    // handshake FSM with registered result, overrun flag set-dominant over clear
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= OCIOSO;
            filtrado      <= '0;
            codigo        <= '0;
            erro_multiplo <= 1'b0;
            saida_valida  <= 1'b0;
            sobrescrita   <= 1'b0;
        end else begin
            if (evento) begin
                estado        <= VALIDO;
                saida_valida  <= 1'b1;
                filtrado      <= amostra;
                codigo        <= codigo_novo;
                erro_multiplo <= multiplo;
            end else if (estado == VALIDO && saida_pronta) begin
                estado       <= OCIOSO;
                saida_valida <= 1'b0;
            end
            sobrescrita <= (evento && estado == VALIDO && !saida_pronta) || (sobrescrita && !limpa_erro);
        end
    end
endmodule

// File: tb/tb_codificador_sequencial_parametrizado.sv
// tb_codificador_sequencial_parametrizado: table-driven check of both encoding modes sharing one stimulus stream
module tb_codificador_sequencial_parametrizado;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] entrada = '0;
    logic       saida_pronta = 1'b0;
    logic       limpa_erro = 1'b0;
    logic [2:0] cod0, cod1;
    logic       val0, val1, err0, err1, sob0, sob1;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       r;
        logic [6:0] e;
        logic       p;
        logic       l;
        logic [2:0] c0;
        logic [2:0] c1;
        logic       v;
        logic       er;
        logic       s;
    } vec_t;
    vec_t tab[$];

    always #5 clk = ~clk;

    codificador_sequencial_parametrizado #(.MODO_PRIORIDADE(0)) d0 (
        .clk(clk), .reset(reset), .entrada(entrada), .saida_pronta(saida_pronta), .limpa_erro(limpa_erro),
        .codigo(cod0), .saida_valida(val0), .erro_multiplo(err0), .sobrescrita(sob0));

    codificador_sequencial_parametrizado #(.MODO_PRIORIDADE(1)) d1 (
        .clk(clk), .reset(reset), .entrada(entrada), .saida_pronta(saida_pronta), .limpa_erro(limpa_erro),
        .codigo(cod1), .saida_valida(val1), .erro_multiplo(err1), .sobrescrita(sob1));

    task automatic chk(input string nome, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    task automatic addn(input int n, input logic r, input logic [6:0] e, input logic p, input logic l,
                        input logic [2:0] c0, input logic [2:0] c1, input logic v, input logic er, input logic s);
        vec_t t;
        t = '{r, e, p, l, c0, c1, v, er, s};
        for (int k = 0; k < n; k++) tab.push_back(t);
    endtask

    initial begin
        int n;
        addn(1, 1, 7'h00, 1, 0, 0, 0, 0, 0, 0);
        addn(1, 0, 7'h00, 1, 0, 0, 0, 0, 0, 0);
        addn(2, 0, 7'h04, 1, 0, 0, 0, 0, 0, 0);
        addn(5, 0, 7'h00, 1, 0, 0, 0, 0, 0, 0);
        addn(4, 0, 7'h40, 1, 0, 0, 0, 0, 0, 0);
        addn(1, 0, 7'h40, 1, 0, 1, 1, 1, 0, 0);
        addn(1, 0, 7'h40, 1, 0, 1, 1, 0, 0, 0);
        addn(4, 0, 7'h00, 1, 0, 1, 1, 0, 0, 0);
        addn(1, 0, 7'h00, 1, 0, 0, 0, 1, 0, 0);
        addn(1, 0, 7'h00, 1, 0, 0, 0, 0, 0, 0);
        addn(4, 0, 7'h01, 0, 0, 0, 0, 0, 0, 0);
        addn(6, 0, 7'h01, 0, 0, 7, 7, 1, 0, 0);
        addn(1, 0, 7'h01, 1, 0, 7, 7, 0, 0, 0);
        addn(4, 0, 7'h24, 1, 0, 7, 7, 0, 0, 0);
        addn(1, 0, 7'h24, 1, 0, 0, 2, 1, 1, 0);
        addn(1, 0, 7'h24, 1, 0, 0, 2, 0, 1, 0);
        addn(4, 0, 7'h10, 0, 0, 0, 2, 0, 1, 0);
        addn(1, 0, 7'h10, 0, 0, 3, 3, 1, 0, 0);
        addn(4, 0, 7'h08, 0, 0, 3, 3, 1, 0, 0);
        addn(1, 0, 7'h08, 0, 0, 4, 4, 1, 0, 1);
        addn(1, 0, 7'h08, 0, 1, 4, 4, 1, 0, 0);
        addn(4, 0, 7'h10, 0, 0, 4, 4, 1, 0, 0);
        addn(1, 0, 7'h10, 0, 1, 3, 3, 1, 0, 1);
        addn(1, 0, 7'h10, 0, 0, 3, 3, 1, 0, 1);
        addn(1, 0, 7'h10, 0, 1, 3, 3, 1, 0, 0);
        addn(4, 0, 7'h08, 0, 0, 3, 3, 1, 0, 0);
        addn(1, 0, 7'h08, 1, 0, 4, 4, 1, 0, 0);
        addn(1, 0, 7'h04, 1, 0, 4, 4, 0, 0, 0);
        addn(3, 0, 7'h04, 0, 0, 4, 4, 0, 0, 0);
        addn(1, 0, 7'h04, 0, 0, 5, 5, 1, 0, 0);
        addn(1, 1, 7'h04, 0, 0, 0, 0, 0, 0, 0);
        addn(5, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0);

        foreach (tab[k]) begin
            reset        = tab[k].r;
            entrada      = tab[k].e;
            saida_pronta = tab[k].p;
            limpa_erro   = tab[k].l;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d codigo_m0", k), cod0, tab[k].c0);
            chk($sformatf("row%0d codigo_m1", k), cod1, tab[k].c1);
            chk($sformatf("row%0d valida_m0", k), val0, tab[k].v);
            chk($sformatf("row%0d valida_m1", k), val1, tab[k].v);
            chk($sformatf("row%0d erro_m0", k), err0, tab[k].er);
            chk($sformatf("row%0d erro_m1", k), err1, tab[k].er);
            chk($sformatf("row%0d sobrescrita_m0", k), sob0, tab[k].s);
            chk($sformatf("row%0d sobrescrita_m1", k), sob1, tab[k].s);
        end

        reset        = 1'b0;
        limpa_erro   = 1'b0;
        saida_pronta = 1'b0;
        entrada      = 7'h40;
        repeat (3) @(posedge clk);
        #1;
        entrada = 7'h20;
        n = 0;
        while (!val0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latencia_apos_troca", n, 5);
        chk("codigo_troca_m0", cod0, 2);
        chk("codigo_troca_m1", cod1, 2);
        chk("sobrescrita_troca", sob0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
